// File: rtl/jogo_unidade_controle.sv
// jogo_unidade_controle: memory-game control FSM with move edge detection and per-move timeout
module jogo_unidade_controle #(
    parameter int TIMEOUT    = 5000,
    parameter bit TIMEOUT_EN = 1'b1,
    parameter int TW         = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       fimC,
    input  logic       igual,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hC,
        FIM_ERRO    = 4'hE
    } estado_t;
    estado_t       estado_q, estado_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          jogada_q;
    logic          jogada_p;
    logic          expirou;
    assign jogada_p = jogada & ~jogada_q;
    assign expirou  = TIMEOUT_EN && (cnt_q == TW'(TIMEOUT - 1));
    // state, move-timeout counter and previous button level
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            cnt_q    <= '0;
            jogada_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            jogada_q <= jogada;
        end
    end
    // next state; counter only runs while waiting for a move
    always_comb begin
        estado_d = INICIAL;
        cnt_d    = (TIMEOUT_EN && estado_q == ESPERA) ? cnt_q + 1'b1 : '0;
        case (estado_q)
            INICIAL:     estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  estado_d = ESPERA;
            ESPERA:      estado_d = jogada_p ? REGISTRA : expirou ? FIM_TIMEOUT : ESPERA;
            REGISTRA:    estado_d = COMPARACAO;
            COMPARACAO:  estado_d = !igual ? FIM_ERRO : fimC ? FIM_ACERTO : PROXIMO;
            PROXIMO:     estado_d = ESPERA;
            FIM_ACERTO:  estado_d = iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:    estado_d = iniciar ? PREPARACAO : FIM_ERRO;
            FIM_TIMEOUT: estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:     estado_d = INICIAL;
        endcase
    end
    // Moore outputs; unused encodings show 0xF on the debug port
    always_comb begin
        zeraC     = estado_q == INICIAL || estado_q == PREPARACAO;
        zeraR     = zeraC;
        registraR = estado_q == REGISTRA;
        contaC    = estado_q == PROXIMO;
        acertou   = estado_q == FIM_ACERTO;
        timeout   = estado_q == FIM_TIMEOUT;
        errou     = estado_q == FIM_ERRO || timeout;
        pronto    = acertou || errou;
        db_estado = 4'hF;
        case (estado_q)
            INICIAL, PREPARACAO, ESPERA, REGISTRA, COMPARACAO, PROXIMO,
            FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: db_estado = estado_q;
            default:                           db_estado = 4'hF;
        endcase
    end
endmodule

// File: tb/tb_jogo_unidade_controle.sv
// tb_jogo_unidade_controle: directed checks of the memory-game control unit with a 4-position datapath model
module tb_jogo_unidade_controle;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b1;
    logic       fimC;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic [1:0] pos;
    int         nvec = 0;
    int         nerr = 0;
    int         nreg = 0;
    int         ncnt = 0;

    jogo_unidade_controle #(.TIMEOUT(8), .TIMEOUT_EN(1'b1), .TW(16)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .fimC(fimC), .igual(igual), .zeraC(zeraC), .contaC(contaC),
        .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
        .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // position counter of the datapath, last position is 3
    always @(posedge clock) pos <= zeraC ? 2'd0 : contaC ? pos + 2'd1 : pos;
    assign fimC = (pos == 2'd3);

    task automatic tick();
        @(posedge clock);
        #1;
        if (registraR) nreg++;
        if (contaC) ncnt++;
    endtask

    task automatic chk_state(input string nm, input logic [3:0] exp);
        nvec++;
        if (db_estado !== exp) begin
            nerr++;
            $display("FAIL %s: db_estado=%h expected %h", nm, db_estado, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [7:0] exp);
        logic [7:0] got;
        got = {zeraC, zeraR, registraR, contaC, pronto, acertou, errou, timeout};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: outputs{zC,zR,rR,cC,pr,ac,er,to}=%b expected %b", nm, got, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: count=%0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic start();
        iniciar = 1'b1;
        tick();
        chk_state("start_prep", 4'h1);
        iniciar = 1'b0;
        tick();
        chk_state("start_espera", 4'h2);
    endtask

    task automatic press(input logic ig);
        igual = ig;
        jogada = 1'b1;
        tick();
        chk_state("press_registra", 4'h4);
        jogada = 1'b0;
        tick();
        chk_state("press_comparacao", 4'h5);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_state("reset_state", 4'h0);
        chk_out("reset_out", 8'b1100_0000);
        repeat (3) tick();
        chk_state("reset_idle", 4'h0);
    endtask

    task automatic test_correct_game();
        int bad;
        nreg = 0;
        ncnt = 0;
        start();
        for (int i = 0; i < 4; i++) begin
            press(1'b1);
            if (i < 3) begin
                chk_state("game_proximo", 4'h6);
                tick();
            end
        end
        chk_state("game_acerto", 4'hA);
        chk_out("game_acerto_out", 8'b0000_1100);
        chk_cnt("game_registraR", nreg, 4);
        chk_cnt("game_contaC", ncnt, 3);
        bad = 0;
        repeat (20) begin
            tick();
            if (db_estado !== 4'hA) bad++;
        end
        chk_cnt("game_hold_bad_cycles", bad, 0);
        start();
    endtask

    task automatic test_wrong_move();
        ncnt = 0;
        press(1'b1);
        chk_state("wrong_first_ok", 4'h6);
        tick();
        press(1'b0);
        chk_state("wrong_erro", 4'hE);
        chk_out("wrong_out", 8'b0000_1010);
        chk_cnt("wrong_contaC", ncnt, 1);
    endtask

    task automatic test_timeout();
        int bad;
        start();
        bad = 0;
        repeat (7) begin
            tick();
            if (db_estado !== 4'h2) bad++;
        end
        chk_cnt("timeout_wait_bad_cycles", bad, 0);
        tick();
        chk_state("timeout_state", 4'hC);
        chk_out("timeout_out", 8'b0000_1011);
        start();
        repeat (7) tick();
        chk_state("timeout_last_cycle", 4'h2);
        jogada = 1'b1;
        tick();
        chk_state("timeout_move_wins", 4'h4);
        chk_out("timeout_move_out", 8'b0010_0000);
        jogada = 1'b0;
        igual = 1'b1;
        tick();
        tick();
        chk_state("timeout_variant_proximo", 4'h6);
        tick();
        chk_state("timeout_variant_espera", 4'h2);
    endtask

    task automatic test_held_button();
        nreg = 0;
        igual = 1'b1;
        jogada = 1'b1;
        repeat (10) tick();
        chk_cnt("held_registraR", nreg, 1);
        chk_state("held_espera", 4'h2);
        jogada = 1'b0;
        tick();
        chk_state("held_release", 4'h2);
        jogada = 1'b1;
        tick();
        chk_state("held_new_press", 4'h4);
        chk_cnt("held_registraR_2", nreg, 2);
        jogada = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_midgame();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start();
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        tick();
        chk_state("mid_comparacao", 4'h5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_state("mid_reset_comp", 4'h0);
        chk_out("mid_reset_comp_out", 8'b1100_0000);
        start();
        repeat (5) tick();
        chk_state("mid_espera_cnt5", 4'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_state("mid_reset_espera", 4'h0);
        start();
        repeat (7) tick();
        chk_state("mid_full_wait", 4'h2);
        tick();
        chk_state("mid_timeout", 4'hC);
    endtask

    initial begin
        test_reset();
        test_correct_game();
        test_wrong_move();
        test_timeout();
        test_held_button();
        test_reset_midgame();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/jogo_unidade_controle.md
Name: jogo_unidade_controle

Overview:
Parametrised successor of the experiment-3 control unit, for the memory-game datapath (position counter, input register, comparator).
- Waits for each player move through an internal rising-edge detector instead of free-running.
- Adds a configurable per-move timeout.
- Reports correct, wrong and timeout as distinct terminal states.
- Holds the result until the next start.
- Sits between the top-level buttons and the datapath; drives counter and register control and debug outputs.

Parameters:
TIMEOUT, 5000, clock cycles allowed per move in the wait state before the game ends by timeout (>=2).
TIMEOUT_EN, 1, 1 = timeout active; 0 = wait state never times out.
TW, 16, width of the internal timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; forces inicial on next edge
iniciar  in  1  start / restart game (level, sampled each edge)
jogada  in  1  level: any player button pressed (already synchronised)
fimC  in  1  datapath counter at last position
igual  in  1  datapath comparator: registered move equals stored value
zeraC  out  1  clear position counter
contaC  out  1  increment position counter
zeraR  out  1  clear move register
registraR  out  1  load move register
pronto  out  1  game finished (any terminal state)
acertou  out  1  whole sequence correct
errou  out  1  wrong move or timeout
timeout  out  1  game ended by timeout
db_estado  out  4  debug state code

Behaviour:
- Reset: synchronous; at the first edge with reset=1:
  - state goes to inicial; timeout counter and jogada_d clear to 0.
  - outputs are zeraC=1, zeraR=1, all others 0, db_estado=0x0.
  - This applies from any state, mid-game included.
- Edge detect:
  - jogada_d registers jogada each edge.
  - jogada_p = jogada & ~jogada_d.
  - A held button yields exactly one pulse.
  - Pulses outside espera are discarded.
- States and transitions (db_estado code in brackets):
  - inicial [0x0]: iniciar -> preparacao; else stay.
  - preparacao [0x1]: -> espera.
  - espera [0x2]:
    - jogada_p -> registra.
    - else if TIMEOUT_EN and counter == TIMEOUT-1 -> fim_timeout.
    - else stay.
  - registra [0x4]: -> comparacao.
  - comparacao [0x5]:
    - ~igual -> fim_erro.
    - igual & fimC -> fim_acerto.
    - igual & ~fimC -> proximo.
  - proximo [0x6]: -> espera.
  - fim_acerto [0xA], fim_erro [0xE], fim_timeout [0xC]: iniciar -> preparacao; else hold.
  - Any unused encoding -> inicial next edge; db_estado shows 0xF while in it.
- Timeout counter:
  - Increments each edge while in espera; cleared to 0 in every other state.
  - Restarts from 0 on each entry to espera.
  - jogada_p on the same cycle the counter reaches TIMEOUT-1: the move wins (-> registra).
  - With TIMEOUT_EN=0 the counter stays at 0.
- Outputs (Moore, decoded from state only):
  - zeraC = zeraR = inicial | preparacao.
  - registraR = registra.
  - contaC = proximo.
  - pronto = any of the three terminal states.
  - acertou = fim_acerto only.
  - errou = fim_erro | fim_timeout.
  - timeout = fim_timeout only.
- Latency:
  - jogada rising edge sampled at edge k: registra from k, comparacao from k+1, proximo/terminal from k+2.
  - iniciar sampled at edge k: preparacao from k; espera from k+1.
- Priority: reset > all. In comparacao, igual is evaluated before fimC, so a wrong last move is an error, never a success.

Test Plan (TIMEOUT=8, TIMEOUT_EN=1, datapath modelled with N=4 positions):
- Reset then idle: reset 1 cycle -> db_estado=0x0, zeraC=zeraR=1, pronto=acertou=errou=timeout=0; stays put with iniciar=0.
- Full correct game: iniciar; 4 presses with igual=1, fimC=1 on the 4th -> exactly 4 registraR pulses, 3 contaC pulses; ends in 0xA with pronto=acertou=1; holds 20 cycles until iniciar -> 0x1.
- Wrong move: iniciar; 2nd press with igual=0 -> 0xE, pronto=errou=1, acertou=0, contaC pulsed once only.
- Timeout: iniciar; no press -> 8 cycles in 0x2, then 0xC with timeout=errou=pronto=1. Variant: press on the 8th cycle -> 0x4, no timeout.
- Held button: jogada held high 10 cycles in espera -> exactly one registraR pulse; state returns to 0x2 after proximo and waits for a release then a new press.
- Reset mid-game: assert reset in comparacao and in espera with counter=5 -> 0x0 on next edge; after iniciar the counter restarts at 0 (full 8 cycles to timeout).
